// File: rtl/sample_scheduler_pkg.sv
// Shared state encodings for the sample scheduler.
// The encodings are visible to the debug port and to anything that decodes it.
package sample_scheduler_pkg;

   localparam int SCHED_STATE_W = 2;

   typedef enum logic [SCHED_STATE_W-1:0] {
      SCHED_IDLE      = 2'd0,
      SCHED_WAIT_BUSY = 2'd1,
      SCHED_WAIT_DONE = 2'd2,
      SCHED_FAULT     = 2'd3
   } sched_state_t;

endpackage

// File: rtl/sample_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear beats increment.
// Used for the overrun count and the issue-to-capture latency counter.
module sat_counter #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [width-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + width'(1);
      end
   end

endmodule

// File: rtl/sample_scheduler.sv
// Holds one ADC sample, issues it to the effect pipeline as a one-cycle tick,
// captures the result for the DAC, and drops to dry passthrough if the pipeline hangs.
module sample_scheduler
   import sample_scheduler_pkg::*;
#(
   parameter int data_width     = 16,
   parameter int timeout_cycles = 4096,
   parameter int stat_width     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [data_width-1:0]    adc_sample,
   input  logic                     adc_valid,
   input  logic                     bypass,
   input  logic                     clear_stats,
   output logic [data_width-1:0]    pipe_in_sample,
   output logic                     pipe_in_valid,
   input  logic                     pipe_ready,
   input  logic [data_width-1:0]    pipe_out_sample,
   output logic [data_width-1:0]    dac_sample,
   output logic                     dac_valid,
   output logic                     busy,
   output logic [stat_width-1:0]    overrun_count,
   output logic [stat_width-1:0]    max_latency,
   output logic                     timeout_error,
   output logic [SCHED_STATE_W-1:0] debug_state
);

   // Handshake: pipe_in_valid is a one-cycle issue pulse, only sent while pipe_ready
   // is high; the pipeline drops pipe_ready while processing and raising it again
   // marks pipe_out_sample valid for capture in that same cycle.

   localparam logic [stat_width-1:0] timeout_last = stat_width'(timeout_cycles - 1);

   sched_state_t            state;
   sched_state_t            state_next;
   logic [data_width-1:0]   slot;
   logic                    pending;
   logic [stat_width-1:0]   lat_ctr;
   logic                    issue;
   logic                    capture;
   logic                    timeout_hit;
   logic                    direct;
   logic                    waiting;
   logic                    overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SCHED_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      issue       = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      direct      = 1'b0;
      waiting     = 1'b0;
      case (state)
         SCHED_IDLE: begin
            if (bypass) begin
               direct = 1'b1;
            end else if (pending && pipe_ready) begin
               issue      = 1'b1;
               state_next = SCHED_WAIT_BUSY;
            end
         end
         SCHED_WAIT_BUSY: begin
            waiting = 1'b1;
            if (lat_ctr >= timeout_last) begin
               timeout_hit = 1'b1;
               state_next  = SCHED_FAULT;
            end else if (!pipe_ready) begin
               state_next = SCHED_WAIT_DONE;
            end
         end
         SCHED_WAIT_DONE: begin
            waiting = 1'b1;
            // A completion that arrives on the last allowed cycle still counts.
            if (pipe_ready) begin
               capture    = 1'b1;
               state_next = SCHED_IDLE;
            end else if (lat_ctr >= timeout_last) begin
               timeout_hit = 1'b1;
               state_next  = SCHED_FAULT;
            end
         end
         SCHED_FAULT: begin
            direct = 1'b1;
         end
         default: begin
            state_next = SCHED_IDLE;
         end
      endcase
   end

   // Overwriting an occupied slot is an overrun, unless that slot leaves this cycle.
   assign overrun = adc_valid && !direct && pending && !issue;

   always_ff @(posedge clk) begin
      if (reset) begin
         slot    <= '0;
         pending <= 1'b0;
      end else if (adc_valid && !direct) begin
         slot    <= adc_sample;
         pending <= 1'b1;
      end else if (issue) begin
         pending <= 1'b0;
      end
   end

   sat_counter #(.width(stat_width)) u_overrun_ctr (
      .clk   (clk),
      .reset (reset),
      .clear (clear_stats),
      .inc   (overrun),
      .count (overrun_count)
   );

   sat_counter #(.width(stat_width)) u_lat_ctr (
      .clk   (clk),
      .reset (reset),
      .clear (issue),
      .inc   (waiting),
      .count (lat_ctr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_in_sample <= '0;
         pipe_in_valid  <= 1'b0;
         dac_sample     <= '0;
         dac_valid      <= 1'b0;
         busy           <= 1'b0;
         timeout_error  <= 1'b0;
         max_latency    <= '0;
      end else begin
         pipe_in_valid <= issue;
         dac_valid     <= 1'b0;
         if (issue) begin
            pipe_in_sample <= slot;
         end
         if (capture) begin
            dac_sample <= pipe_out_sample;
            dac_valid  <= 1'b1;
         end else if (direct && adc_valid) begin
            dac_sample <= adc_sample;
            dac_valid  <= 1'b1;
         end
         if (issue) begin
            busy <= 1'b1;
         end else if (capture || timeout_hit) begin
            busy <= 1'b0;
         end
         if (timeout_hit) begin
            timeout_error <= 1'b1;
         end
         if (clear_stats) begin
            max_latency <= '0;
         end else if (capture && (lat_ctr > max_latency)) begin
            max_latency <= lat_ctr;
         end
      end
   end

   assign debug_state = state;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: a handshaking pipeline model (output = input + 1)
// on one instance and a hanging pipeline on a short-timeout instance.
module tb_sample_scheduler;
   import sample_scheduler_pkg::*;

   localparam int DW = 16;
   localparam int SW = 16;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- main instance ----------------
   logic [DW-1:0]            adc_sample  = '0;
   logic                     adc_valid   = 1'b0;
   logic                     bypass      = 1'b0;
   logic                     clear_stats = 1'b0;
   logic [DW-1:0]            pipe_in_sample;
   logic                     pipe_in_valid;
   logic                     pipe_ready  = 1'b1;
   logic [DW-1:0]            pipe_out_sample;
   logic [DW-1:0]            dac_sample;
   logic                     dac_valid;
   logic                     busy;
   logic [SW-1:0]            overrun_count;
   logic [SW-1:0]            max_latency;
   logic                     timeout_error;
   logic [SCHED_STATE_W-1:0] debug_state;

   assign pipe_out_sample = pipe_in_sample + 16'd1;

   sample_scheduler #(.data_width(DW), .timeout_cycles(4096), .stat_width(SW)) dut (
      .clk             (clk),
      .reset           (reset),
      .adc_sample      (adc_sample),
      .adc_valid       (adc_valid),
      .bypass          (bypass),
      .clear_stats     (clear_stats),
      .pipe_in_sample  (pipe_in_sample),
      .pipe_in_valid   (pipe_in_valid),
      .pipe_ready      (pipe_ready),
      .pipe_out_sample (pipe_out_sample),
      .dac_sample      (dac_sample),
      .dac_valid       (dac_valid),
      .busy            (busy),
      .overrun_count   (overrun_count),
      .max_latency     (max_latency),
      .timeout_error   (timeout_error),
      .debug_state     (debug_state)
   );

   // ---------------- short-timeout instance ----------------
   logic [DW-1:0]            adc2_sample  = '0;
   logic                     adc2_valid   = 1'b0;
   logic                     bypass2      = 1'b0;
   logic                     clear2       = 1'b0;
   logic [DW-1:0]            pipe_in_sample2;
   logic                     pipe_in_valid2;
   logic                     ready2       = 1'b1;
   logic [DW-1:0]            pipe_out_sample2;
   logic [DW-1:0]            dac_sample2;
   logic                     dac_valid2;
   logic                     busy2;
   logic [SW-1:0]            overrun_count2;
   logic [SW-1:0]            max_latency2;
   logic                     timeout_error2;
   logic [SCHED_STATE_W-1:0] debug_state2;

   assign pipe_out_sample2 = pipe_in_sample2 + 16'd1;

   sample_scheduler #(.data_width(DW), .timeout_cycles(16), .stat_width(SW)) dut2 (
      .clk             (clk),
      .reset           (reset),
      .adc_sample      (adc2_sample),
      .adc_valid       (adc2_valid),
      .bypass          (bypass2),
      .clear_stats     (clear2),
      .pipe_in_sample  (pipe_in_sample2),
      .pipe_in_valid   (pipe_in_valid2),
      .pipe_ready      (ready2),
      .pipe_out_sample (pipe_out_sample2),
      .dac_sample      (dac_sample2),
      .dac_valid       (dac_valid2),
      .busy            (busy2),
      .overrun_count   (overrun_count2),
      .max_latency     (max_latency2),
      .timeout_error   (timeout_error2),
      .debug_state     (debug_state2)
   );

   // ---------------- pipeline model: ready drops 1 cycle after issue, low for low_len cycles
   int model_phase = 0;
   int low_left    = 0;
   int low_len     = 4;

   always @(posedge clk) begin
      #2;
      if (reset) begin
         pipe_ready  = 1'b1;
         model_phase = 0;
      end else begin
         case (model_phase)
            0: if (pipe_in_valid) model_phase = 1;
            1: begin
               pipe_ready  = 1'b0;
               low_left    = low_len;
               model_phase = 2;
            end
            default: begin
               low_left = low_left - 1;
               if (low_left == 0) begin
                  pipe_ready  = 1'b1;
                  model_phase = 0;
               end
            end
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int n_issue  = 0;
   int n_dac    = 0;
   int n2_issue = 0;
   int n2_dac   = 0;
   logic [DW-1:0] issue_q[$];
   logic [DW-1:0] dac_q[$];
   logic [DW-1:0] dac2_q[$];
   logic [DW-1:0] exp_q[$];

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (pipe_in_valid) begin
            n_issue++;
            issue_q.push_back(pipe_in_sample);
         end
         if (dac_valid) begin
            n_dac++;
            dac_q.push_back(dac_sample);
         end
         if (pipe_in_valid2) n2_issue++;
         if (dac_valid2) begin
            n2_dac++;
            dac2_q.push_back(dac_sample2);
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [DW-1:0] v);
      adc_sample = v;
      adc_valid  = 1'b1;
      @(negedge clk);
      adc_valid  = 1'b0;
   endtask

   task automatic send2(input logic [DW-1:0] v);
      adc2_sample = v;
      adc2_valid  = 1'b1;
      @(negedge clk);
      adc2_valid  = 1'b0;
   endtask

   task automatic wait_issue(input int n);
      for (int i = 0; i < 100 && n_issue < n; i++) @(negedge clk);
      if (n_issue < n) check("wait_issue_bound", n_issue, n);
   endtask

   task automatic wait_dac(input int n);
      for (int i = 0; i < 100 && n_dac < n; i++) @(negedge clk);
      if (n_dac < n) check("wait_dac_bound", n_dac, n);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("rst_pipe_in_valid", pipe_in_valid, 0);
      check("rst_pipe_in_sample", pipe_in_sample, 0);
      check("rst_dac_valid", dac_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun_count, 0);
      check("rst_timeout", timeout_error, 0);
      check("rst_state", debug_state, SCHED_IDLE);
      reset = 1'b0;
      @(negedge clk);

      // single sample through a 5-cycle pipeline
      send(16'h1234);
      exp_q.push_back(16'h1235);
      wait_dac(1);
      repeat (2) @(negedge clk);
      check("t1_issues", n_issue, 1);
      check("t1_issue_val", issue_q[0], 16'h1234);
      check("t1_dac_count", n_dac, 1);
      check("t1_max_latency", max_latency, 5);
      check("t1_overrun", overrun_count, 0);
      check("t1_busy_after", busy, 0);

      // three strobes inside a 20-cycle processing window
      low_len = 20;
      send(16'h0010);
      exp_q.push_back(16'h0011);
      wait_issue(2);
      send(16'h0001);
      @(negedge clk);
      send(16'h0002);
      @(negedge clk);
      send(16'h0003);
      check("t2_overrun", overrun_count, 2);
      check("t2_busy", busy, 1);
      check("t2_pipe_in_held", pipe_in_sample, 16'h0010);
      check("t2_state", debug_state, SCHED_WAIT_DONE);
      wait_dac(2);
      check("t2_no_issue_at_capture", n_issue, 2);
      wait_issue(3);
      check("t2_next_issue", issue_q[2], 16'h0003);
      exp_q.push_back(16'h0004);
      low_len = 4;

      // new sample arriving in the exact issue cycle
      send(16'h0055);
      wait_dac(3);
      send(16'h0066);
      wait_issue(4);
      check("t3_issued_old", issue_q[3], 16'h0055);
      check("t3_overrun_same", overrun_count, 2);
      exp_q.push_back(16'h0056);
      wait_dac(4);
      wait_issue(5);
      check("t3_pending_new", issue_q[4], 16'h0066);
      exp_q.push_back(16'h0067);
      wait_dac(5);
      check("t3_max_latency", max_latency, 21);

      // bypass: ADC straight to DAC with one cycle latency
      @(negedge clk);
      bypass = 1'b1;
      send(16'h8000);
      exp_q.push_back(16'h8000);
      check("t5_bypass_latency", n_dac, 6);
      check("t5_bypass_val", dac_sample, 16'h8000);
      repeat (4) @(negedge clk);
      check("t5_no_issue", n_issue, 5);
      bypass = 1'b0;

      // clear_stats
      clear_stats = 1'b1;
      @(negedge clk);
      clear_stats = 1'b0;
      check("clr_overrun", overrun_count, 0);
      check("clr_max_latency", max_latency, 0);

      // reset in WAIT_DONE with clear_stats and an overrun together
      send(16'h0100);
      wait_issue(6);
      send(16'h0200);
      repeat (2) @(negedge clk);
      check("t6_pre_state", debug_state, SCHED_WAIT_DONE);
      reset       = 1'b1;
      clear_stats = 1'b1;
      adc_sample  = 16'h0300;
      adc_valid   = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
      clear_stats = 1'b0;
      adc_valid   = 1'b0;
      check("t6_state", debug_state, SCHED_IDLE);
      check("t6_busy", busy, 0);
      check("t6_dac_sample", dac_sample, 0);
      check("t6_pipe_in_sample", pipe_in_sample, 0);
      check("t6_overrun", overrun_count, 0);
      check("t6_max_latency", max_latency, 0);
      repeat (8) @(negedge clk);
      check("t6_no_dac", n_dac, 6);
      check("t6_pending_dropped", n_issue, 6);

      // hung pipeline on the 16-cycle timeout instance
      send2(16'h0A0A);
      for (int i = 0; i < 10 && n2_issue < 1; i++) @(negedge clk);
      check("to_issued", n2_issue, 1);
      ready2 = 1'b0;
      repeat (15) @(negedge clk);
      check("to_not_yet", timeout_error2, 0);
      check("to_busy_before", busy2, 1);
      @(negedge clk);
      check("to_error", timeout_error2, 1);
      check("to_busy_after", busy2, 0);
      check("to_state", debug_state2, SCHED_FAULT);
      check("to_no_dac", n2_dac, 0);
      send2(16'h7FFF);
      check("to_fault_dac_count", n2_dac, 1);
      check("to_fault_dac_val", dac_sample2, 16'h7FFF);
      repeat (3) @(negedge clk);
      check("to_fault_no_issue", n2_issue, 1);
      check("to_error_sticky", timeout_error2, 1);

      // whole DAC stream of the main instance against the expected queue
      check("dac_stream_len", dac_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < dac_q.size()) check("dac_stream", dac_q[i], exp_q[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
